if_fetch: RTL and testbench
===========================

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 RESET_PC, 32'h8000_0000, PC value loaded by reset.
REQ-002 EXC_PC, 32'h8000_0004, exception redirect target (present only with IF_FETCH_EXC_EN).
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 imem_req  output  1  instruction-memory request.
REQ-006 imem_addr  output  32  word-aligned fetch address; stable while imem_req=1.
REQ-007 imem_ack  input  1  request complete this cycle; meaningful only when imem_req=1.
REQ-008 imem_rdata  input  32  instruction word, valid with imem_ack.
REQ-009 fetch_stall  input  1  downstream (IFID) hold; 1 = word not consumed this edge.
REQ-010 branch_taken  input  1  branch redirect request.
REQ-011 branch_target  input  32  branch redirect address.
REQ-012 jump  input  1  jump redirect request.
REQ-013 jump_target  input  32  jump redirect address.
REQ-014 exception  input  1  exception redirect request (ignored without IF_FETCH_EXC_EN).
REQ-015 PC_out  output  32  fetched instruction address + 4, feeds IFID PC_in.
REQ-016 Instruct_out  output  32  fetched instruction, feeds IFID Instruct_in.
REQ-017 fetch_valid  output  1  PC_out/Instruct_out hold a valid word.
REQ-018 IFID_flush  output  1  one-cycle pulse that clears IFID after a redirect.

Function
REQ-019 Output slot (PC_out, Instruct_out, fetch_valid) is registered; a word is consumed at an edge where fetch_valid=1 and fetch_stall=0.
REQ-020 One skid entry SHALL absorb an imem_ack arriving while the output slot is full and not consumed; the skid moves to the output slot at the next consuming edge.
REQ-021 States: IDLE (no request), FETCH (imem_req=1, addr=PC), SQUASH (imem_req=1, addr=stale PC, returned word dropped).
REQ-022 IDLE->FETCH when skid entry empty; FETCH stays until imem_ack; no new request is issued while the skid entry is occupied (FETCH->IDLE on ack in that case).
REQ-023 FETCH with imem_ack and no redirect: word captured (output slot, or skid if blocked), PC <= PC+4, PC_out = fetched address + 4.
REQ-024 Redirect = exception | branch_taken | jump in a cycle; priority exception > branch_taken > jump; target latched as new PC.
REQ-025 Redirect overrides fetch_stall: output slot and skid entry are cleared and fetch_valid=0 at the next edge, IFID_flush=1 for exactly that following cycle.
REQ-026 Redirect in FETCH without imem_ack -> SQUASH, imem_addr held at stale value until ack; on ack the word is discarded and FETCH starts at the latched target next cycle.
REQ-027 Redirect in FETCH with imem_ack the same cycle: returned word discarded, FETCH at target next cycle.
REQ-028 Redirect while in SQUASH: latched target replaced by the new one (latest wins); IFID_flush pulses again.
REQ-029 Redirect in IDLE: FETCH at target next cycle.
REQ-030 Target and PC low two bits are forced to 2'b00; PC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-031 Fetch-to-output latency: word visible on Instruct_out the cycle after imem_ack when the slot is free.

Reset
REQ-032 reset=1 at an edge: state IDLE, PC=RESET_PC, PC_out=0, Instruct_out=0, fetch_valid=0, IFID_flush=0, skid empty, imem_req=0.
REQ-033 Reset mid-request abandons it; an imem_ack in the cycle after reset is ignored; FETCH of RESET_PC begins the second cycle after reset deasserts.

Configuration
REQ-034 Macro IF_FETCH_EXC_EN: defined -> exception input and EXC_PC active with top redirect priority; undefined -> exception ignored, EXC_PC unused, all other behaviour identical.

Verification
REQ-035 Reset, imem_ack every cycle, no stall -> fetches 0x80000000, 0x80000004, 0x80000008 in consecutive cycles; PC_out 0x80000004, 0x80000008, 0x8000000C.
REQ-036 imem_ack delayed 3 cycles -> imem_addr stable 4 cycles, fetch_valid low until the cycle after ack.
REQ-037 fetch_stall=1 for 4 cycles with continuous acks -> exactly one word in skid, no request while skid full, no word lost or duplicated after release.
REQ-038 branch_taken=1, branch_target=0x80000100 during a pending fetch -> SQUASH, stale word dropped, IFID_flush one cycle, next valid word from 0x80000100.
REQ-039 exception, branch_taken, jump all high in one cycle (EXC_EN defined) -> next fetch at 0x80000004; with macro undefined -> fetch at branch_target.
REQ-040 PC=0xFFFFFFFC fetched -> PC_out 0x00000000, next imem_addr 0x00000000.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction fetch stage: PC sequencing, a registered output slot with one skid entry, and redirect squashing.
// Define IF_FETCH_EXC_EN to enable the exception redirect to EXC_PC, which has top priority.
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter logic [31:0] EXC_PC   = 32'h8000_0004
) (
   input  logic        CLK,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        fetch_stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   input  logic        exception,
   output logic [31:0] PC_out,
   output logic [31:0] Instruct_out,
   output logic        fetch_valid,
   output logic        IFID_flush
);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      SQUASH
   } state_t;

   state_t      state, state_next;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] stale_addr;
   logic        skid_valid;
   logic [31:0] skid_pc;
   logic [31:0] skid_instr;

   logic        redirect;
   logic [31:0] target_raw;
   logic [31:0] redirect_pc;
   logic        consume;
   logic        slot_free;
   logic        word_ack;

   always_comb begin
      redirect   = branch_taken | jump;
      target_raw = branch_taken ? branch_target : jump_target;
`ifdef IF_FETCH_EXC_EN
      if (exception) begin
         redirect   = 1'b1;
         target_raw = EXC_PC;
      end
`endif
      redirect_pc = target_raw & 32'hFFFF_FFFC;
   end

`ifndef IF_FETCH_EXC_EN
   logic unused_exc;
   assign unused_exc = ^{exception, EXC_PC};
`endif

   assign pc_plus4  = pc + 32'd4;
   assign consume   = fetch_valid & ~fetch_stall;
   assign slot_free = ~fetch_valid | consume;
   // Only an unsquashed acknowledge in FETCH delivers a word; the skid is always empty while in FETCH.
   assign word_ack  = (state == FETCH) & imem_ack & ~redirect;

   always_ff @(posedge CLK) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      imem_req   = 1'b0;
      imem_addr  = pc;
      case (state)
         IDLE: begin
            if (redirect || !skid_valid) begin
               state_next = FETCH;
            end
         end
         FETCH: begin
            imem_req = 1'b1;
            if (redirect) begin
               state_next = imem_ack ? FETCH : SQUASH;
            end else if (imem_ack && !slot_free) begin
               state_next = IDLE;
            end
         end
         SQUASH: begin
            imem_req  = 1'b1;
            imem_addr = stale_addr;
            if (imem_ack) begin
               state_next = FETCH;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         pc           <= RESET_PC;
         stale_addr   <= '0;
         skid_valid   <= 1'b0;
         skid_pc      <= '0;
         skid_instr   <= '0;
         fetch_valid  <= 1'b0;
         PC_out       <= '0;
         Instruct_out <= '0;
         IFID_flush   <= 1'b0;
      end else begin
         IFID_flush <= redirect;
         if (redirect) begin
            pc <= redirect_pc;
            // The abandoned request keeps its address on the bus until memory acknowledges it.
            if (state == FETCH) begin
               stale_addr <= pc;
            end
            fetch_valid  <= 1'b0;
            PC_out       <= '0;
            Instruct_out <= '0;
            skid_valid   <= 1'b0;
         end else begin
            if (word_ack) begin
               pc <= pc_plus4;
            end
            if (word_ack && slot_free) begin
               fetch_valid  <= 1'b1;
               PC_out       <= pc_plus4;
               Instruct_out <= imem_rdata;
            end else if (word_ack) begin
               skid_valid <= 1'b1;
               skid_pc    <= pc_plus4;
               skid_instr <= imem_rdata;
            end else if (consume) begin
               fetch_valid  <= skid_valid;
               PC_out       <= skid_pc;
               Instruct_out <= skid_instr;
               skid_valid   <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: per-cycle vector table plus scoreboard of words consumed downstream.
`timescale 1ns/1ps
module tb_if_fetch;

   localparam logic [31:0] K = 32'h1357_9BDF;
`ifdef IF_FETCH_EXC_EN
   localparam logic [31:0] E39    = 32'h8000_0004;
   localparam logic        EXC_ON = 1'b1;
`else
   localparam logic [31:0] E39    = 32'h8000_0500;
   localparam logic        EXC_ON = 1'b0;
`endif

   logic        CLK;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        fetch_stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic [31:0] jump_target;
   logic        exception;
   logic [31:0] PC_out;
   logic [31:0] Instruct_out;
   logic        fetch_valid;
   logic        IFID_flush;

   if_fetch dut (
      .CLK           (CLK),
      .reset         (reset),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .fetch_stall   (fetch_stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
      .exception     (exception),
      .PC_out        (PC_out),
      .Instruct_out  (Instruct_out),
      .fetch_valid   (fetch_valid),
      .IFID_flush    (IFID_flush)
   );

   // Memory model: every word is its own address scrambled by a constant.
   assign imem_rdata = imem_addr ^ K;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic        rst, ack, stall, br;
      logic [31:0] bt;
      logic        jp;
      logic [31:0] jt;
      logic        exc, push;
      logic [31:0] push_addr;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_pcout;
      logic        e_flush;
   } vec_t;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] sb[$];
   vec_t        tbl[35];

   function automatic vec_t mk(input logic rst, ack, stall, br, input logic [31:0] bt,
                               input logic jp, input logic [31:0] jt, input logic exc, push,
                               input logic [31:0] push_addr, input logic e_req,
                               input logic [31:0] e_addr, input logic e_valid,
                               input logic [31:0] e_pcout, input logic e_flush);
      vec_t v;
      v.rst = rst; v.ack = ack; v.stall = stall; v.br = br; v.bt = bt; v.jp = jp; v.jt = jt;
      v.exc = exc; v.push = push; v.push_addr = push_addr; v.e_req = e_req; v.e_addr = e_addr;
      v.e_valid = e_valid; v.e_pcout = e_pcout; v.e_flush = e_flush;
      return v;
   endfunction

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs at the falling edge, then check outputs one falling edge later.
   task automatic step(input vec_t t, input string tag);
      logic        redir;
      logic [31:0] exp_a;
      reset         = t.rst;
      imem_ack      = t.ack;
      fetch_stall   = t.stall;
      branch_taken  = t.br;
      branch_target = t.bt;
      jump          = t.jp;
      jump_target   = t.jt;
      exception     = t.exc;
      redir = t.br | t.jp | (t.exc & EXC_ON);
      if (t.rst || redir) begin
         sb.delete();
      end else if (fetch_valid && !t.stall) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s.sb_underflow: word consumed with none expected, PC_out %h", tag, PC_out);
         end else begin
            exp_a = sb.pop_front();
            chk32({tag, ".sb_pc"}, PC_out, exp_a + 32'd4);
            chk32({tag, ".sb_instr"}, Instruct_out, exp_a ^ K);
         end
      end
      if (t.push) sb.push_back(t.push_addr);
      @(posedge CLK);
      @(negedge CLK);
      chk32({tag, ".req"}, {31'b0, imem_req}, {31'b0, t.e_req});
      if (t.e_req) chk32({tag, ".addr"}, imem_addr, t.e_addr);
      chk32({tag, ".valid"}, {31'b0, fetch_valid}, {31'b0, t.e_valid});
      if (t.e_valid) begin
         chk32({tag, ".pc_out"}, PC_out, t.e_pcout);
         chk32({tag, ".instr"}, Instruct_out, (t.e_pcout - 32'd4) ^ K);
      end
      if (t.rst) begin
         chk32({tag, ".rst_pc_out"}, PC_out, 32'h0);
         chk32({tag, ".rst_instr"}, Instruct_out, 32'h0);
      end
      chk32({tag, ".flush"}, {31'b0, IFID_flush}, {31'b0, t.e_flush});
   endtask

   initial begin
      reset = 1'b1; imem_ack = 1'b0; fetch_stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
      jump = 1'b0; jump_target = '0; exception = 1'b0;

      //            rst ack stl br bt            jp jt            exc push paddr          req addr           vld pc_out         flush
      tbl[0]  = mk(1, 0, 0, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0);
      tbl[1]  = mk(0, 1, 0, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0,         1, 32'h8000_0000, 0, 32'h0,         0);
      tbl[2]  = mk(0, 1, 0, 0, 32'h0,         0, 32'h0,         0, 1, 32'h8000_0000, 1, 32'h8000_0004, 1, 32'h8000_0004, 0);
      tbl[3]  = mk(0, 1, 0, 0, 32'h0,         0, 32'h0,         0, 1, 32'h8000_0004, 1, 32'h8000_0008, 1, 32'h8000_0008, 0);
      tbl[4]  = mk(0, 1, 0, 0, 32'h0,         0, 32'h0,         0, 1, 32'h8000_0008, 1, 32'h8000_000C, 1, 32'h8000_000C, 0);
      tbl[5]  = mk(0, 0, 0, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0,         1, 32'h8000_000C, 0, 32'h0,         0);
      tbl[6]  = mk(0, 0, 0, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0,         1, 32'h8000_000C, 0, 32'h0,         0);
      tbl[7]  = mk(0, 0, 0, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0,         1, 32'h8000_000C, 0, 32'h0,         0);
      tbl[8]  = mk(0, 1, 0, 0, 32'h0,         0, 32'h0,         0, 1, 32'h8000_000C, 1, 32'h8000_0010, 1, 32'h8000_0010, 0);
      tbl[9]  = mk(0, 1, 1, 0, 32'h0,         0, 32'h0,         0, 1, 32'h8000_0010, 0, 32'h0,         1, 32'h8000_0010, 0);
      tbl[10] = mk(0, 1, 1, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         1, 32'h8000_0010, 0);
      tbl[11] = mk(0, 1, 1, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         1, 32'h8000_0010, 0);
      tbl[12] = mk(0, 1, 1, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         1, 32'h8000_0010, 0);
      tbl[13] = mk(0, 1, 0, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         1, 32'h8000_0014, 0);
      tbl[14] = mk(0, 1, 0, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0,         1, 32'h8000_0014, 0, 32'h0,         0);
      tbl[15] = mk(0, 1, 0, 0, 32'h0,         0, 32'h0,         0, 1, 32'h8000_0014, 1, 32'h8000_0018, 1, 32'h8000_0018, 0);
      tbl[16] = mk(0, 0, 1, 1, 32'h8000_0100, 0, 32'h0,         0, 0, 32'h0,         1, 32'h8000_0018, 0, 32'h0,         1);
      tbl[17] = mk(0, 0, 0, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0,         1, 32'h8000_0018, 0, 32'h0,         0);
      tbl[18] = mk(0, 1, 0, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0,         1, 32'h8000_0100, 0, 32'h0,         0);
      tbl[19] = mk(0, 1, 0, 0, 32'h0,         0, 32'h0,         0, 1, 32'h8000_0100, 1, 32'h8000_0104, 1, 32'h8000_0104, 0);
      tbl[20] = mk(0, 1, 0, 0, 32'h0,         1, 32'h8000_0203, 0, 0, 32'h0,         1, 32'h8000_0200, 0, 32'h0,         1);
      tbl[21] = mk(0, 0, 0, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0,         1, 32'h8000_0200, 0, 32'h0,         0);
      tbl[22] = mk(0, 0, 0, 1, 32'h8000_0300, 0, 32'h0,         0, 0, 32'h0,         1, 32'h8000_0200, 0, 32'h0,         1);
      tbl[23] = mk(0, 0, 0, 0, 32'h0,         1, 32'h8000_0400, 0, 0, 32'h0,         1, 32'h8000_0200, 0, 32'h0,         1);
      tbl[24] = mk(0, 0, 0, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0,         1, 32'h8000_0200, 0, 32'h0,         0);
      tbl[25] = mk(0, 1, 0, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0,         1, 32'h8000_0400, 0, 32'h0,         0);
      tbl[26] = mk(0, 1, 0, 0, 32'h0,         0, 32'h0,         0, 1, 32'h8000_0400, 1, 32'h8000_0404, 1, 32'h8000_0404, 0);
      tbl[27] = mk(0, 1, 0, 1, 32'h8000_0500, 1, 32'h8000_0600, 1, 0, 32'h0,         1, E39,           0, 32'h0,         1);
      tbl[28] = mk(0, 1, 0, 0, 32'h0,         0, 32'h0,         0, 1, E39,           1, E39 + 32'd4,   1, E39 + 32'd4,   0);
      tbl[29] = mk(0, 0, 0, 1, 32'h8000_0700, 1, 32'h8000_0800, 0, 0, 32'h0,         1, E39 + 32'd4,   0, 32'h0,         1);
      tbl[30] = mk(0, 1, 0, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0,         1, 32'h8000_0700, 0, 32'h0,         0);
      tbl[31] = mk(0, 1, 0, 0, 32'h0,         0, 32'h0,         0, 1, 32'h8000_0700, 1, 32'h8000_0704, 1, 32'h8000_0704, 0);
      tbl[32] = mk(0, 1, 0, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0,         1);
      tbl[33] = mk(0, 1, 0, 0, 32'h0,         0, 32'h0,         0, 1, 32'hFFFF_FFFC, 1, 32'h0,         1, 32'h0,         0);
      tbl[34] = mk(0, 0, 0, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0,         1, 32'h0,         0, 32'h0,         0);

      @(negedge CLK);
      for (int i = 0; i < 35; i++) begin
         step(tbl[i], $sformatf("v%0d", i));
      end

      // Redirect while IDLE with the skid full: both slots emptied, fetch starts at the target.
      step(mk(0, 1, 1, 0, 32'h0, 0, 32'h0, 0, 1, 32'h0, 1, 32'h4, 1, 32'h4, 0), "idle_fill");
      step(mk(0, 1, 1, 0, 32'h0, 0, 32'h0, 0, 1, 32'h4, 0, 32'h0, 1, 32'h4, 0), "idle_skid");
      step(mk(0, 0, 1, 1, 32'h8000_0900, 0, 32'h0, 0, 0, 32'h0, 1, 32'h8000_0900, 0, 32'h0, 1), "idle_redir");
      step(mk(0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 1, 32'h8000_0900, 0, 32'h0, 0), "idle_after");

      // Reset with a full slot and a live request; the ack right after reset must be ignored.
      step(mk(0, 1, 1, 0, 32'h0, 0, 32'h0, 0, 1, 32'h8000_0900, 1, 32'h8000_0904, 1, 32'h8000_0904, 0), "rst_fill");
      step(mk(1, 0, 1, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0), "rst_mid");
      step(mk(0, 1, 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 1, 32'h8000_0000, 0, 32'h0, 0), "rst_ackign");
      step(mk(0, 1, 0, 0, 32'h0, 0, 32'h0, 0, 1, 32'h8000_0000, 1, 32'h8000_0004, 1, 32'h8000_0004, 0), "rst_first");
      step(mk(0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 1, 32'h8000_0004, 0, 32'h0, 0), "rst_drain");

      chk32("sb_leftover", sb.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
